// File: rtl/scalar_logic_pkg.sv
// Shared definitions for the scalar/vector logic unit: operation encodings.
package scalar_logic_pkg;

   typedef enum logic [1:0] {
      OP_AND = 2'b00,
      OP_OR  = 2'b01,
      OP_XOR = 2'b10,
      OP_ACC = 2'b11
   } op_e;

endpackage

// File: rtl/scalar_logic_unit_popcount.sv
// Combinational population count of an N-bit vector.
module popcount #(
   parameter int N = 4
) (
   input  logic [N-1:0]             a,
   output logic [$clog2(N+1)-1:0]   cnt
);

   localparam int PW = $clog2(N + 1);

   always_comb begin
      cnt = '0;
      for (int i = 0; i < N; i++) begin
         cnt = cnt + PW'(a[i]);
      end
   end

endmodule

// File: rtl/scalar_logic_unit.sv
// Scalar-masked AND/OR/XOR/accumulate over an N-bit vector, with a single
// valid/ready output register and a popcount of the held result.
module scalar_logic_unit
   import scalar_logic_pkg::*;
#(
   parameter int N  = 4,
   parameter int PW = $clog2(N + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic          g,
   input  logic [N-1:0]  a,
   input  logic [1:0]    op,
   input  logic          acc_clr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [N-1:0]  y,
   output logic [PW-1:0] pop
);

   function automatic logic [N-1:0] logic_op(
      input op_e          sel,
      input logic [N-1:0] av,
      input logic [N-1:0] m,
      input logic [N-1:0] accv
   );
      logic [N-1:0] r;
      r = '0;
      case (sel)
         OP_AND:  r = av & m;
         OP_OR:   r = av | m;
         OP_XOR:  r = av ^ m;
         OP_ACC:  r = accv;
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [N-1:0] mask_p0;
   logic [N-1:0] acc_next_p0;
   logic [N-1:0] res_p0;
   logic         accept_p0;

   logic [N-1:0] acc_p1;
   logic [N-1:0] y_p1;
   logic         vld_p1;

   // Stage p0: combinational operand decode and result formation
   assign in_ready  = !vld_p1 || out_ready;
   assign accept_p0 = in_valid && in_ready;

   always_comb begin
      mask_p0     = {N{g}};
      acc_next_p0 = (acc_clr ? '0 : acc_p1) | (a & mask_p0);
      res_p0      = logic_op(op_e'(op), a, mask_p0, acc_next_p0);
   end

   // Stage p1: output register and accumulator; reset discards any held result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         y_p1   <= '0;
         acc_p1 <= '0;
      end else if (accept_p0) begin
         vld_p1 <= 1'b1;
         y_p1   <= res_p0;
         if (op_e'(op) == OP_ACC) begin
            acc_p1 <= acc_next_p0;
         end else if (acc_clr) begin
            acc_p1 <= '0;
         end
      end else if (out_ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign out_valid = vld_p1;
   assign y         = y_p1;

   popcount #(
      .N (N)
   ) u_popcount (
      .a   (y_p1),
      .cnt (pop)
   );

endmodule

// File: tb/tb_scalar_logic_unit.sv
// Directed scoreboard bench for scalar_logic_unit at N=4.
module tb_scalar_logic_unit;

   localparam int N  = 4;
   localparam int PW = 3;

   typedef struct {
      logic [N-1:0]  y;
      logic [PW-1:0] pop;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          g = 1'b0;
   logic [N-1:0]  a = '0;
   logic [1:0]    op = 2'b00;
   logic          acc_clr = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [N-1:0]  y;
   logic [PW-1:0] pop;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q[$];
   exp_t mon_e;
   logic mvld = 1'b0;
   logic [N-1:0] macc = '0;

   scalar_logic_unit #(.N(N)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .g         (g),
      .a         (a),
      .op        (op),
      .acc_clr   (acc_clr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .pop       (pop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference occupancy of the output register
   always @(posedge clk) begin
      if (!rst_n) mvld <= 1'b0;
      else if (in_valid && (!mvld || out_ready)) mvld <= 1'b1;
      else if (out_ready) mvld <= 1'b0;
   end

   // Handshake checks and scoreboard consumption, away from the active edge
   always @(negedge clk) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, mvld});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (!mvld || out_ready)});
      if (rst_n && out_valid && out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
         end else begin
            mon_e = q.pop_front();
            chk("y", {28'b0, y}, {28'b0, mon_e.y});
            chk("pop", {29'b0, pop}, {29'b0, mon_e.pop});
         end
      end
   end

   task automatic send(input logic gv, input logic [N-1:0] av, input logic [1:0] opv,
                       input logic clrv);
      exp_t         e;
      logic [N-1:0] m;
      bit           done;
      done     = 0;
      g        = gv;
      a        = av;
      op       = opv;
      acc_clr  = clrv;
      in_valid = 1'b1;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge clk);
         if (!mvld || out_ready) begin
            m = {N{gv}};
            case (opv)
               2'b00: e.y = av & m;
               2'b01: e.y = av | m;
               2'b10: e.y = av ^ m;
               default: begin
                  macc = (clrv ? 4'b0000 : macc) | (av & m);
                  e.y  = macc;
               end
            endcase
            if (opv != 2'b11 && clrv) macc = '0;
            e.pop = PW'($countones(e.y));
            q.push_back(e);
            done = 1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      // Reset
      repeat (2) @(posedge clk);
      #1;
      chk("rst0_y", {28'b0, y}, 32'd0);
      chk("rst0_pop", {29'b0, pop}, 32'd0);
      chk("rst0_ready", {31'b0, in_ready}, 32'd1);
      rst_n = 1'b1;

      // Basic operations
      send(1'b1, 4'b1010, 2'b00, 1'b0);   // 1010
      send(1'b0, 4'b1010, 2'b00, 1'b0);   // 0000
      send(1'b1, 4'b0101, 2'b01, 1'b0);   // 1111
      send(1'b1, 4'b0101, 2'b10, 1'b0);   // 1010
      send(1'b0, 4'b0101, 2'b10, 1'b0);   // 0101
      send(1'b0, 4'b0011, 2'b01, 1'b0);   // 0011

      // Accumulator
      send(1'b1, 4'b0001, 2'b11, 1'b0);   // 0001
      send(1'b1, 4'b0100, 2'b11, 1'b0);   // 0101
      send(1'b1, 4'b1000, 2'b11, 1'b1);   // 1000
      send(1'b1, 4'b0110, 2'b00, 1'b1);   // 0110, acc cleared
      send(1'b1, 4'b0010, 2'b11, 1'b0);   // 0010

      // Backpressure with a pending beat
      out_ready = 1'b0;
      g = 1'b1; a = 4'b0100; op = 2'b11; acc_clr = 1'b0; in_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("hold_ready", {31'b0, in_ready}, 32'd0);
         chk("hold_y", {28'b0, y}, 32'h2);
         chk("hold_pop", {29'b0, pop}, 32'd1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(1'b1, 4'b0100, 2'b11, 1'b0);   // 0110: acc untouched while stalled
      send(1'b1, 4'b0101, 2'b10, 1'b0);   // 1010

      // Withdrawn offer has no effect
      out_ready = 1'b0;
      g = 1'b1; a = 4'b1111; op = 2'b11; acc_clr = 1'b1; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Back-to-back throughput
      for (int i = 0; i < 8; i++) begin
         send(i[0], 4'(i * 3), 2'(i % 3), 1'b0);
      end

      // Reset while holding a result with a non-zero accumulator
      send(1'b1, 4'b0101, 2'b11, 1'b1);   // acc = 0101
      out_ready = 1'b0;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst1_valid", {31'b0, out_valid}, 32'd0);
      chk("rst1_y", {28'b0, y}, 32'd0);
      chk("rst1_pop", {29'b0, pop}, 32'd0);
      chk("rst1_ready", {31'b0, in_ready}, 32'd1);
      q.delete();
      macc = '0;
      rst_n = 1'b1;
      out_ready = 1'b1;
      send(1'b1, 4'b0010, 2'b11, 1'b0);   // 0010

      // Drain
      for (int c = 0; c < 10 && q.size() != 0; c++) begin
         @(posedge clk);
         #1;
      end
      chk("drain", q.size(), 32'd0);
      @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/scalar_logic_unit.md
SCALAR_LOGIC_UNIT -- requirements
Module: scalar_logic_unit

Interface
REQ-001 SHALL have parameter N, default 4: vector width; legal N >= 1.
REQ-002 SHALL have parameter PW, default $clog2(N+1): popcount width, derived and not overridden.
REQ-003 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1: reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1: input beat offered.
REQ-006 SHALL have port in_ready  output  1: block accepts beat this cycle.
REQ-007 SHALL have port g  input  1: scalar operand.
REQ-008 SHALL have port a  input  N: vector operand.
REQ-009 SHALL have port op  input  2: operation select, sampled with the beat.
REQ-010 SHALL have port acc_clr  input  1: clear accumulator, sampled with the beat.
REQ-011 SHALL have port out_valid  output  1: result held in the output register.
REQ-012 SHALL have port out_ready  input  1: downstream accepts result.
REQ-013 SHALL have port y  output  N: result vector.
REQ-014 SHALL have port pop  output  PW: number of 1 bits in y.

Function
REQ-015 SHALL form the scalar mask m = {N{g}} and compute per op: 00 AND y=a&m; 01 OR y=a|m; 10 XOR y=a^m; 11 ACC y=acc_next.
REQ-016 SHALL, in ACC mode, compute acc_next = (acc_clr ? 0 : acc) | (a&m) and write acc <= acc_next on beat accept.
REQ-017 SHALL leave acc unchanged on accepted beats with op != 11, except that acc_clr=1 on any accepted beat clears acc to 0.
REQ-018 SHALL ignore acc_clr, op, a and g when no beat is accepted.
REQ-019 SHALL accept a beat when in_valid && in_ready.
REQ-020 SHALL drive in_ready = !out_valid || out_ready (combinational; single output register; full throughput).
REQ-021 SHALL register y and pop on accept, so latency is exactly 1 cycle: a beat accepted at edge k is visible at out_valid from edge k onward.
REQ-022 SHALL hold y, pop and out_valid stable while out_valid && !out_ready.
REQ-023 SHALL, on accept with out_valid && out_ready in the same cycle, replace the result with no bubble; out_valid stays 1.
REQ-024 SHALL clear out_valid when out_ready=1 and no new beat is accepted.
REQ-025 SHALL compute pop as the popcount of the registered y, range 0..N, zero-extended to PW bits; no overflow is possible.
REQ-026 SHALL not depend on in_valid/out_ready being held; a withdrawn in_valid before accept has no effect.

Reset
REQ-027 SHALL, when rst_n=0 at a rising edge, set out_valid=0, y=0, pop=0 and acc=0, with priority over any beat in that cycle.
REQ-028 SHALL drive in_ready=1 during and immediately after reset (out_valid=0).
REQ-029 SHALL discard a held, unconsumed result on reset mid-operation; no beat survives reset.

Structure
REQ-030 SHALL take op encodings (OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_ACC=2'b11) from shared package scalar_logic_pkg.
REQ-031 SHALL implement popcount as sub-module popcount, parameter N, output width $clog2(N+1), purely combinational.
REQ-032 SHALL contain no latches and no logic clocked on data signals; the only sensitivity is clk.

Verification (N=4)
REQ-033 SHALL cover: reset then g=1,a=4'b1010,op=AND, out_ready=1 -> next cycle y=4'b1010,pop=2,out_valid=1; g=0 same a -> y=0000,pop=0.
REQ-034 SHALL cover: op=OR g=1 a=0101 -> y=1111,pop=4; op=XOR g=1 a=0101 -> y=1010,pop=2; op=XOR g=0 -> y=0101.
REQ-035 SHALL cover: ACC g=1 beats a=0001,0100,acc_clr=0 -> y=0001 then 0101; next beat a=1000 with acc_clr=1 -> y=1000; AND beat with acc_clr=1 then ACC a=0010 -> y=0010.
REQ-036 SHALL cover: out_ready=0 with result held, in_valid=1 -> in_ready=0, y/pop unchanged for 3 cycles, acc unchanged; out_ready=1 -> pending beat accepted same cycle, next result with no gap.
REQ-037 SHALL cover: back-to-back 8 beats, out_ready=1 continuously -> 8 results on 8 consecutive cycles, in order, in_ready never 0.
REQ-038 SHALL cover: rst_n=0 while out_valid=1,out_ready=0 and acc=0101 -> next cycle out_valid=0,y=0,pop=0; subsequent ACC a=0010 g=1 -> y=0010.
